hms_clock_counter: RTL and testbench
====================================

# hms_clock_counter

Time-of-day counter for the LED clock, directly downstream of the 12 MHz→1 Hz divider. It consumes the divider's 1 Hz square wave, detects each rising edge as one elapsed second, and keeps hours/minutes/seconds in packed BCD with carry and rollover. It accepts a validated time load and drives the five board LEDs plus one-cycle second and day strobes.

## Interface
- No parameters. The clock is fixed at 12 MHz and tick_in is the only timebase.
- clk  in  1  12 MHz system clock
- reset  in  1  synchronous, active-high
- tick_in  in  1  1 Hz square wave from divider, synchronous to clk; each 0→1 transition = one second
- load  in  1  one-cycle strobe: load time from load_hh/load_mm/load_ss
- load_hh  in  8  BCD hours {tens,ones}
- load_mm  in  8  BCD minutes
- load_ss  in  8  BCD seconds
- load_pm  in  1  PM flag for load (present only with CLOCK_12H_EN)
- hours  out  8  BCD hours
- minutes  out  8  BCD minutes
- seconds  out  8  BCD seconds
- pm  out  1  PM flag (present only with CLOCK_12H_EN)
- sec_pulse  out  1  one-cycle strobe per counted second
- day_pulse  out  1  one-cycle strobe on midnight rollover
- load_err  out  1  one-cycle strobe: load rejected
- leds  out  5  leds[3:0] = seconds ones digit (binary), leds[4] = tick_q (heartbeat)

## Operation
- Edge detect: tick_q <= tick_in every cycle. tick_q resets to 1, so the divider's reset-high output does not produce a false edge. edge = tick_in & ~tick_q.
- Priority per cycle: reset > load > edge.
- On edge: seconds +1 in BCD. Ones 9→0 carries into tens. 59→00 carries into minutes. Minutes 59→00 carries into hours.
- 24 h hours: 23:59:59→00:00:00 with day_pulse=1 on the same update. Only the fields that change update.
- Load validation: every ones digit ≤9, tens of mm/ss ≤5, hours ≤23.
  - Valid: all three fields written.
  - Invalid: no field written, load_err=1 for one cycle.
- Edge in the same cycle as load is discarded, not deferred, whether the load is valid or rejected.
- sec_pulse=1 for exactly the cycle following an accepted edge. It is never asserted for a load.
- All outputs registered. No combinational path from inputs to outputs.

## Timing
- Reset values:
  - 24 h mode: hours=00, minutes=00, seconds=00.
  - 12 h mode: hours=12, pm=0.
  - sec_pulse=0, day_pulse=0, load_err=0, leds=5'b10000 (tick_q=1).
- Edge latency: tick_in first high at clock edge N → counters, sec_pulse and day_pulse reflect it after edge N+1. Latency is 1 cycle.
- Load latency: load high at edge N → fields, or load_err, valid after edge N+1.
- A tick_in high pulse of any length ≥1 cycle counts exactly once. A low time of ≥1 cycle is required between edges.
- reset asserted mid-count clears within one cycle. The first edge after reset is counted only after tick_in has been seen low.
- Pulse outputs are one cycle wide and return to 0 unconditionally the next cycle.

## Configuration
- CLOCK_12H_EN defined: 12-hour mode.
  - Hours sequence is 12,01,…,11,12.
  - pm toggles on the 11:59:59→12:00:00 transition.
  - day_pulse fires on the PM 11:59:59→AM 12:00:00 transition.
  - Valid load hours are 01–12. pm <= load_pm on a valid load.
  - Ports load_pm and pm exist.
- CLOCK_12H_EN undefined: 24-hour mode as above. Ports pm and load_pm are absent.

## Test plan
- Reset with tick_in=1, hold 10 cycles → all fields 00, no sec_pulse. Then tick_in 0→1 → seconds=01 one cycle later, sec_pulse one cycle wide.
- Load 23:59:59, then one edge → 00:00:00, day_pulse=1 for one cycle, sec_pulse=1 in the same cycle.
- Load 12:34:56, apply 4 edges → 12:35:00. tick_in held high 20 cycles → counted once.
- Load hh=8'h24 or mm=8'h6A → load_err one cycle, time unchanged. load and edge in the same cycle → loaded value, edge lost, no sec_pulse.
- Assert reset during minute carry (time 00:00:59, edge and reset same cycle) → 00:00:00, no pulses.
- CLOCK_12H_EN: load 11:59:59 pm=0, one edge → 12:00:00 pm=1, no day_pulse. Load 11:59:59 pm=1, one edge → 12:00:00 pm=0, day_pulse=1. Load hh=00 → load_err.

Source files
------------

// File: rtl/hms_clock_counter.sv
// hms_clock_counter: BCD hh:mm:ss time-of-day counter driven by a 1 Hz tick, with validated load and LED outputs.
// Optional feature: define CLOCK_12H_EN for 12-hour mode with pm flag and load_pm input.
module hms_clock_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_in,
    input  logic       load,
    input  logic [7:0] load_hh,
    input  logic [7:0] load_mm,
    input  logic [7:0] load_ss,
`ifdef CLOCK_12H_EN
    input  logic       load_pm,
    output logic       pm,
`endif
    output logic [7:0] hours,
    output logic [7:0] minutes,
    output logic [7:0] seconds,
    output logic       sec_pulse,
    output logic       day_pulse,
    output logic       load_err,
    output logic [4:0] leds
);
`ifdef CLOCK_12H_EN
    localparam logic [7:0] HH_RST = 8'h12;
`else
    localparam logic [7:0] HH_RST = 8'h00;
`endif

    logic [7:0] hh_q, mm_q, ss_q, hh_d, mm_d, ss_d;
    logic [7:0] hh_inc, mm_inc, ss_inc;
    logic       tick_q, sec_q, day_q, err_q, sec_d, day_d, err_d;
    logic       tick_edge, s_wrap, m_wrap, hr_carry, h_wrap, digits_ok, hh_ok, ld_ok;
`ifdef CLOCK_12H_EN
    logic       pm_q, pm_d;
`endif

    // Next-state: load takes priority over the tick edge, and a coincident edge is dropped.
    always_comb begin
        tick_edge = tick_in & ~tick_q;
        s_wrap    = ss_q == 8'h59;
        m_wrap    = mm_q == 8'h59;
        hr_carry  = tick_edge & s_wrap & m_wrap;
        ss_inc    = s_wrap ? 8'h00 : (ss_q[3:0] == 4'd9) ? {ss_q[7:4] + 4'd1, 4'd0} : ss_q + 8'd1;
        mm_inc    = m_wrap ? 8'h00 : (mm_q[3:0] == 4'd9) ? {mm_q[7:4] + 4'd1, 4'd0} : mm_q + 8'd1;
        digits_ok = (load_hh[3:0] <= 4'd9) && (load_mm[3:0] <= 4'd9) && (load_ss[3:0] <= 4'd9)
                 && (load_mm[7:4] <= 4'd5) && (load_ss[7:4] <= 4'd5);
`ifdef CLOCK_12H_EN
        h_wrap    = (hh_q == 8'h11) & pm_q;
        hh_inc    = (hh_q == 8'h12) ? 8'h01 : (hh_q[3:0] == 4'd9) ? 8'h10 : hh_q + 8'd1;
        hh_ok     = (load_hh >= 8'h01) && (load_hh <= 8'h12);
`else
        h_wrap    = hh_q == 8'h23;
        hh_inc    = h_wrap ? 8'h00 : (hh_q[3:0] == 4'd9) ? {hh_q[7:4] + 4'd1, 4'd0} : hh_q + 8'd1;
        hh_ok     = load_hh <= 8'h23;
`endif
        ld_ok     = digits_ok & hh_ok;
        ss_d      = load ? (ld_ok ? load_ss : ss_q) : tick_edge ? ss_inc : ss_q;
        mm_d      = load ? (ld_ok ? load_mm : mm_q) : (tick_edge & s_wrap) ? mm_inc : mm_q;
        hh_d      = load ? (ld_ok ? load_hh : hh_q) : hr_carry ? hh_inc : hh_q;
        sec_d     = ~load & tick_edge;
        day_d     = ~load & hr_carry & h_wrap;
        err_d     = load & ~ld_ok;
`ifdef CLOCK_12H_EN
        pm_d      = load ? (ld_ok ? load_pm : pm_q) : (hr_carry & (hh_q == 8'h11)) ? ~pm_q : pm_q;
`endif
    end

    // State and output registers; tick_q resets high so a held-high tick is not an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            hh_q   <= HH_RST;
            mm_q   <= 8'h00;
            ss_q   <= 8'h00;
            tick_q <= 1'b1;
            sec_q  <= 1'b0;
            day_q  <= 1'b0;
            err_q  <= 1'b0;
`ifdef CLOCK_12H_EN
            pm_q   <= 1'b0;
`endif
        end else begin
            hh_q   <= hh_d;
            mm_q   <= mm_d;
            ss_q   <= ss_d;
            tick_q <= tick_in;
            sec_q  <= sec_d;
            day_q  <= day_d;
            err_q  <= err_d;
`ifdef CLOCK_12H_EN
            pm_q   <= pm_d;
`endif
        end
    end

    assign hours     = hh_q;
    assign minutes   = mm_q;
    assign seconds   = ss_q;
    assign sec_pulse = sec_q;
    assign day_pulse = day_q;
    assign load_err  = err_q;
    assign leds      = {tick_q, ss_q[3:0]};
`ifdef CLOCK_12H_EN
    assign pm        = pm_q;
`endif
endmodule

// File: tb/tb_hms_clock_counter.sv
// tb_hms_clock_counter: table-driven directed check of hms_clock_counter, one vector per clock.
module tb_hms_clock_counter;
    typedef struct {
        logic       r, t, l, lp;
        logic [7:0] lh, lm, ls, eh, em, es;
        logic       epm, esp, edp, eer;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1, tick_in = 1'b1, load = 1'b0;
    logic [7:0] load_hh = 8'h00, load_mm = 8'h00, load_ss = 8'h00;
    logic [7:0] hours, minutes, seconds;
    logic       sec_pulse, day_pulse, load_err, pm_w;
    logic [4:0] leds;
    int         n_vec = 0, n_bad = 0;
    vec_t       tbl[$];
`ifdef CLOCK_12H_EN
    localparam logic [7:0] RST_HH = 8'h12;
    logic load_pm = 1'b0;
`else
    localparam logic [7:0] RST_HH = 8'h00;
    assign pm_w = 1'b0;
`endif

    always #5 clk = ~clk;

    hms_clock_counter dut (
        .clk(clk), .reset(reset), .tick_in(tick_in), .load(load),
        .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss),
`ifdef CLOCK_12H_EN
        .load_pm(load_pm), .pm(pm_w),
`endif
        .hours(hours), .minutes(minutes), .seconds(seconds),
        .sec_pulse(sec_pulse), .day_pulse(day_pulse), .load_err(load_err), .leds(leds)
    );

    function automatic vec_t mk(input logic r, t, l, lp, input logic [7:0] lh, lm, ls, eh, em, es,
                                input logic epm, esp, edp, eer);
        vec_t v;
        v.r = r; v.t = t; v.l = l; v.lp = lp; v.lh = lh; v.lm = lm; v.ls = ls;
        v.eh = eh; v.em = em; v.es = es; v.epm = epm; v.esp = esp; v.edp = edp; v.eer = eer;
        return v;
    endfunction

    task automatic step(input string nm, input vec_t v);
        logic [4:0] el;
        reset = v.r; tick_in = v.t; load = v.l; load_hh = v.lh; load_mm = v.lm; load_ss = v.ls;
`ifdef CLOCK_12H_EN
        load_pm = v.lp;
`endif
        @(posedge clk);
        #1;
        el = {v.r ? 1'b1 : v.t, v.es[3:0]};
        n_vec++;
        if ({hours, minutes, seconds, pm_w, sec_pulse, day_pulse, load_err, leds} !==
            {v.eh, v.em, v.es, v.epm, v.esp, v.edp, v.eer, el}) begin
            n_bad++;
            $display("FAIL %s: got %h:%h:%h pm=%b sp=%b dp=%b err=%b leds=%b, want %h:%h:%h pm=%b sp=%b dp=%b err=%b leds=%b",
                     nm, hours, minutes, seconds, pm_w, sec_pulse, day_pulse, load_err, leds,
                     v.eh, v.em, v.es, v.epm, v.esp, v.edp, v.eer, el);
        end
    endtask

    initial begin
        for (int i = 0; i < 10; i++)
            step("reset_hold", mk(1,1,0,0, 8'h00,8'h00,8'h00, RST_HH,8'h00,8'h00, 0,0,0,0));
`ifdef CLOCK_12H_EN
        tbl.push_back(mk(0,1,0,0, 8'h00,8'h00,8'h00, 8'h12,8'h00,8'h00, 0,0,0,0));
        tbl.push_back(mk(0,0,1,0, 8'h11,8'h59,8'h59, 8'h11,8'h59,8'h59, 0,0,0,0));
        tbl.push_back(mk(0,1,0,0, 8'h00,8'h00,8'h00, 8'h12,8'h00,8'h00, 1,1,0,0));
        tbl.push_back(mk(0,0,1,1, 8'h11,8'h59,8'h59, 8'h11,8'h59,8'h59, 1,0,0,0));
        tbl.push_back(mk(0,1,0,0, 8'h00,8'h00,8'h00, 8'h12,8'h00,8'h00, 0,1,1,0));
        tbl.push_back(mk(0,0,0,0, 8'h00,8'h00,8'h00, 8'h12,8'h00,8'h00, 0,0,0,0));
        tbl.push_back(mk(0,1,0,0, 8'h00,8'h00,8'h00, 8'h12,8'h00,8'h01, 0,1,0,0));
        tbl.push_back(mk(0,0,1,0, 8'h12,8'h59,8'h59, 8'h12,8'h59,8'h59, 0,0,0,0));
        tbl.push_back(mk(0,1,0,0, 8'h00,8'h00,8'h00, 8'h01,8'h00,8'h00, 0,1,0,0));
        tbl.push_back(mk(0,0,1,0, 8'h00,8'h00,8'h00, 8'h01,8'h00,8'h00, 0,0,0,1));
        tbl.push_back(mk(0,0,1,0, 8'h13,8'h00,8'h00, 8'h01,8'h00,8'h00, 0,0,0,1));
        tbl.push_back(mk(0,0,1,1, 8'h09,8'h59,8'h59, 8'h09,8'h59,8'h59, 1,0,0,0));
        tbl.push_back(mk(0,1,0,0, 8'h00,8'h00,8'h00, 8'h10,8'h00,8'h00, 1,1,0,0));
`else
        tbl.push_back(mk(0,1,0,0, 8'h00,8'h00,8'h00, 8'h00,8'h00,8'h00, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0, 8'h00,8'h00,8'h00, 8'h00,8'h00,8'h00, 0,0,0,0));
        tbl.push_back(mk(0,1,0,0, 8'h00,8'h00,8'h00, 8'h00,8'h00,8'h01, 0,1,0,0));
        tbl.push_back(mk(0,1,0,0, 8'h00,8'h00,8'h00, 8'h00,8'h00,8'h01, 0,0,0,0));
        tbl.push_back(mk(0,0,1,0, 8'h23,8'h59,8'h59, 8'h23,8'h59,8'h59, 0,0,0,0));
        tbl.push_back(mk(0,1,0,0, 8'h00,8'h00,8'h00, 8'h00,8'h00,8'h00, 0,1,1,0));
        tbl.push_back(mk(0,0,0,0, 8'h00,8'h00,8'h00, 8'h00,8'h00,8'h00, 0,0,0,0));
        tbl.push_back(mk(0,0,1,0, 8'h12,8'h34,8'h56, 8'h12,8'h34,8'h56, 0,0,0,0));
        tbl.push_back(mk(0,1,0,0, 8'h00,8'h00,8'h00, 8'h12,8'h34,8'h57, 0,1,0,0));
        tbl.push_back(mk(0,0,0,0, 8'h00,8'h00,8'h00, 8'h12,8'h34,8'h57, 0,0,0,0));
        tbl.push_back(mk(0,1,0,0, 8'h00,8'h00,8'h00, 8'h12,8'h34,8'h58, 0,1,0,0));
        tbl.push_back(mk(0,0,0,0, 8'h00,8'h00,8'h00, 8'h12,8'h34,8'h58, 0,0,0,0));
        tbl.push_back(mk(0,1,0,0, 8'h00,8'h00,8'h00, 8'h12,8'h34,8'h59, 0,1,0,0));
        tbl.push_back(mk(0,0,0,0, 8'h00,8'h00,8'h00, 8'h12,8'h34,8'h59, 0,0,0,0));
        tbl.push_back(mk(0,1,0,0, 8'h00,8'h00,8'h00, 8'h12,8'h35,8'h00, 0,1,0,0));
        tbl.push_back(mk(0,0,1,0, 8'h24,8'h00,8'h00, 8'h12,8'h35,8'h00, 0,0,0,1));
        tbl.push_back(mk(0,0,0,0, 8'h00,8'h00,8'h00, 8'h12,8'h35,8'h00, 0,0,0,0));
        tbl.push_back(mk(0,0,1,0, 8'h12,8'h6A,8'h00, 8'h12,8'h35,8'h00, 0,0,0,1));
        tbl.push_back(mk(0,1,1,0, 8'h09,8'h09,8'h09, 8'h09,8'h09,8'h09, 0,0,0,0));
        tbl.push_back(mk(0,1,0,0, 8'h00,8'h00,8'h00, 8'h09,8'h09,8'h09, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0, 8'h00,8'h00,8'h00, 8'h09,8'h09,8'h09, 0,0,0,0));
        tbl.push_back(mk(0,0,1,0, 8'h00,8'h00,8'h59, 8'h00,8'h00,8'h59, 0,0,0,0));
        tbl.push_back(mk(1,1,0,0, 8'h00,8'h00,8'h00, 8'h00,8'h00,8'h00, 0,0,0,0));
        tbl.push_back(mk(0,1,0,0, 8'h00,8'h00,8'h00, 8'h00,8'h00,8'h00, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0, 8'h00,8'h00,8'h00, 8'h00,8'h00,8'h00, 0,0,0,0));
        tbl.push_back(mk(0,1,0,0, 8'h00,8'h00,8'h00, 8'h00,8'h00,8'h01, 0,1,0,0));
        tbl.push_back(mk(0,0,1,0, 8'h01,8'h59,8'h59, 8'h01,8'h59,8'h59, 0,0,0,0));
        tbl.push_back(mk(0,1,0,0, 8'h00,8'h00,8'h00, 8'h02,8'h00,8'h00, 0,1,0,0));
        tbl.push_back(mk(0,0,1,0, 8'h09,8'h59,8'h59, 8'h09,8'h59,8'h59, 0,0,0,0));
        tbl.push_back(mk(0,1,0,0, 8'h00,8'h00,8'h00, 8'h10,8'h00,8'h00, 0,1,0,0));
        tbl.push_back(mk(0,0,1,0, 8'h00,8'h00,8'h0A, 8'h10,8'h00,8'h00, 0,0,0,1));
        tbl.push_back(mk(0,1,1,0, 8'h30,8'h00,8'h00, 8'h10,8'h00,8'h00, 0,0,0,1));
        tbl.push_back(mk(0,1,0,0, 8'h00,8'h00,8'h00, 8'h10,8'h00,8'h00, 0,0,0,0));
`endif
        foreach (tbl[i])
            step($sformatf("vec%0d", i), tbl[i]);
        step("hold_load", mk(0,0,1,0, 8'h10,8'h00,8'h00, 8'h10,8'h00,8'h00, 0,0,0,0));
        step("hold_first", mk(0,1,0,0, 8'h00,8'h00,8'h00, 8'h10,8'h00,8'h01, 0,1,0,0));
        for (int i = 0; i < 19; i++)
            step("hold_high", mk(0,1,0,0, 8'h00,8'h00,8'h00, 8'h10,8'h00,8'h01, 0,0,0,0));
        step("hold_release", mk(0,0,0,0, 8'h00,8'h00,8'h00, 8'h10,8'h00,8'h01, 0,0,0,0));
        step("hold_next", mk(0,1,0,0, 8'h00,8'h00,8'h00, 8'h10,8'h00,8'h02, 0,1,0,0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
